// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_ERR     = 3'd4
   } imem_ld_state_t;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage : imem_ctrl_pkg

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: one synchronous write port, one asynchronous read port.
module imem_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Storage only; contents are undefined until a load writes them.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : imem_ram

// File: rtl/imem_load_ctrl.sv
// Streams a program image into instruction RAM while holding the core in reset, then serves fetches.
// Optional XOR checksum on the last beat is enabled by defining IMEM_LOAD_CSUM_EN.
module imem_load_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
`ifdef IMEM_LOAD_CSUM_EN
   input  logic [31:0]   ld_csum,
`endif
   input  logic [31:0]   cpu_pc,
   output logic [31:0]   cpu_instr,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          pc_fault,
   output logic [AW:0]   words_loaded
);

   imem_ld_state_t state_q, state_d;
   logic [AW:0]    addr_q, addr_d;
   logic           pc_fault_q, pc_fault_d;

   logic           start_acc;
   logic [AW:0]    beat_addr;
   logic           csum_ok;
   logic           pc_oob;
   logic           ram_we;
   logic [AW-1:0]  ram_waddr;
   logic [31:0]    ram_rdata;
   logic           unused_pc;

   // A start pulse is honoured everywhere except the single RELEASE cycle.
   assign start_acc = ld_start && (state_q != ST_RELEASE);
   assign beat_addr = start_acc ? '0 : addr_q;
   assign pc_oob    = (cpu_pc >> (AW + 2)) != 32'd0;
   assign unused_pc = ^cpu_pc[1:0];

`ifdef IMEM_LOAD_CSUM_EN
   logic [31:0] csum_q, csum_base;

   assign csum_base = start_acc ? 32'd0 : csum_q;
   assign csum_ok   = (csum_base ^ ld_data) == ld_csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= 32'd0;
      end else begin
         csum_q <= ram_we ? (csum_base ^ ld_data) : csum_base;
      end
   end
`else
   assign csum_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         pc_fault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         pc_fault_q <= pc_fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      pc_fault_d = pc_fault_q;
      ram_we     = 1'b0;
      ram_waddr  = beat_addr[AW-1:0];

      if (start_acc) begin
         state_d    = ST_LOAD;
         addr_d     = '0;
         pc_fault_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: ;
         ST_LOAD: begin
            if (ld_valid) begin
               ram_we = 1'b1;
               addr_d = beat_addr + (AW+1)'(1);
               if (ld_last) begin
                  state_d = csum_ok ? ST_RELEASE : ST_ERR;
               end else if (beat_addr == (AW+1)'(DEPTH - 1)) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_RELEASE: state_d = ST_RUN;
         ST_RUN: begin
            if (!start_acc && pc_oob) begin
               pc_fault_d = 1'b1;
            end
         end
         ST_ERR: ;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ld_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      cpu_rst_n = 1'b0;
      cpu_instr = RV_NOP;
      unique case (state_q)
         ST_LOAD: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_RUN: begin
            cpu_rst_n = 1'b1;
            done      = 1'b1;
            if (!pc_oob) begin
               cpu_instr = ram_rdata;
            end
         end
         ST_ERR:  err = 1'b1;
         default: ;
      endcase
   end

   assign pc_fault     = pc_fault_q;
   assign words_loaded = addr_q;

   imem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ld_data),
      .raddr_i (cpu_pc[AW+1:2]),
      .rdata_o (ram_rdata)
   );

endmodule : imem_load_ctrl

// File: tb/tb_imem_load_ctrl.sv
// Directed + randomized bench for imem_load_ctrl against a word-array reference model.
module tb_imem_load_ctrl;
   import imem_ctrl_pkg::*;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_start, ld_valid, ld_ready, ld_last;
   logic [31:0] ld_data, cpu_pc, cpu_instr;
`ifdef IMEM_LOAD_CSUM_EN
   logic [31:0] ld_csum;
`endif
   logic        cpu_rst_n, busy, done, err, pc_fault;
   logic [AW:0] words_loaded;

   imem_load_ctrl #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ld_start     (ld_start),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
`ifdef IMEM_LOAD_CSUM_EN
      .ld_csum      (ld_csum),
`endif
      .cpu_pc       (cpu_pc),
      .cpu_instr    (cpu_instr),
      .cpu_rst_n    (cpu_rst_n),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .pc_fault     (pc_fault),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: image as a plain word array plus accepted-beat count and running XOR.
   logic [31:0] m_mem [DEPTH];
   int          m_addr;
   logic [31:0] m_csum;

   // Status vector {cpu_rst_n, busy, done, err, ld_ready} for each phase of a load.
   localparam logic [4:0] S_IDLE = 5'b00000;
   localparam logic [4:0] S_LOAD = 5'b01001;
   localparam logic [4:0] S_REL  = 5'b00000;
   localparam logic [4:0] S_RUN  = 5'b10100;
   localparam logic [4:0] S_ERR  = 5'b00010;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic [4:0] exp);
      chk(tag, 32'({cpu_rst_n, busy, done, err, ld_ready}), 32'(exp));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      m_addr   = 0;
      m_csum   = 32'd0;
   endtask

   task automatic beat_cs(input logic [31:0] d, input logic last, input logic [31:0] cs);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
`ifdef IMEM_LOAD_CSUM_EN
      ld_csum  = cs;
`endif
      if (cs == 32'hFFFF_FFFF) ld_csum_dummy();
      chk("ld_ready_on_beat", 32'(ld_ready), 32'd1);
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      m_mem[m_addr % DEPTH] = d;
      m_addr++;
      m_csum ^= d;
   endtask

   task automatic ld_csum_dummy();
   endtask

   task automatic beat(input logic [31:0] d, input logic last);
      beat_cs(d, last, m_csum ^ d);
   endtask

   task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
      cpu_pc = pc;
      #1;
      chk(tag, cpu_instr, exp);
   endtask

   task automatic chk_reset_values(input string tag);
      chk_status({tag, "_status"}, S_IDLE);
      chk({tag, "_words"}, 32'(words_loaded), 32'd0);
      chk({tag, "_pc_fault"}, 32'(pc_fault), 32'd0);
      chk({tag, "_instr"}, cpu_instr, RV_NOP);
   endtask

   // Release phase: one cycle with the core held, then running.
   task automatic finish_release(input int n, input logic poke);
      chk_status("release_status", S_REL);
      chk("release_instr", cpu_instr, RV_NOP);
      ld_start = poke;
      step();
      ld_start = 1'b0;
      chk_status("run_status", S_RUN);
      chk("run_words", 32'(words_loaded), 32'(n));
   endtask

   task automatic random_load(input int n, input logic poke);
      logic [31:0] w;
      do_start();
      chk_status("rnd_load_status", S_LOAD);
      chk("rnd_load_words0", 32'(words_loaded), 32'd0);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            step();
            chk("rnd_gap_rst", 32'(cpu_rst_n), 32'd0);
         end
         w = $urandom;
         beat(w, i == n - 1);
      end
      finish_release(n, poke);
      for (int k = 0; k < 6; k++) begin
         int unsigned idx;
         idx = $urandom_range(0, n - 1);
         fetch("rnd_fetch", {24'd0, idx[5:0], 2'($urandom)}, m_mem[idx]);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = 32'd0;
      cpu_pc   = 32'd0;
`ifdef IMEM_LOAD_CSUM_EN
      ld_csum  = 32'd0;
`endif
      m_addr   = 0;
      m_csum   = 32'd0;

      step();
      step();
      chk_reset_values("reset");
      rst_n = 1'b1;
      step();
      chk_status("idle_after_reset", S_IDLE);

      // Basic 3-word load.
      do_start();
      chk_status("basic_load_status", S_LOAD);
      beat(32'h0050_0113, 1'b0);
      beat(32'h00C0_0193, 1'b0);
      beat(32'hFF71_8393, 1'b1);
      finish_release(3, 1'b0);
      fetch("basic_pc8", 32'd8, 32'hFF71_8393);
      fetch("basic_pc0", 32'd0, 32'h0050_0113);
      fetch("basic_pc5", 32'd5, 32'h00C0_0193);

      // Out-of-range fetch: NOP now, sticky fault after the edge.
      fetch("fault_instr", 32'h0000_0100, RV_NOP);
      chk("fault_pre", 32'(pc_fault), 32'd0);
      step();
      chk("fault_set", 32'(pc_fault), 32'd1);
      cpu_pc = 32'd0;
      step();
      chk("fault_sticky", 32'(pc_fault), 32'd1);
      fetch("fault_inrange", 32'd0, 32'h0050_0113);

      // Reload from RUN.
      do_start();
      chk_status("reload_status", S_LOAD);
      chk("reload_fault_clr", 32'(pc_fault), 32'd0);
      chk("reload_words", 32'(words_loaded), 32'd0);
      chk("reload_instr", cpu_instr, RV_NOP);
      beat(32'h0000_0063, 1'b1);
      finish_release(1, 1'b0);
      fetch("reload_pc0", 32'd0, 32'h0000_0063);

      // Overflow: DEPTH beats without a last marker.
      do_start();
      for (int i = 0; i < int'(DEPTH); i++) beat($urandom, 1'b0);
      chk_status("ovf_status", S_ERR);
      chk("ovf_words", 32'(words_loaded), 32'(DEPTH));
      chk("ovf_instr", cpu_instr, RV_NOP);
      step();
      step();
      chk_status("ovf_hold", S_ERR);
      do_start();
      chk_status("ovf_clear", S_LOAD);

      // Restart mid-load with a coincident beat.
      for (int i = 0; i < 5; i++) beat($urandom, 1'b0);
      chk("pre_restart_words", 32'(words_loaded), 32'd5);
      ld_start = 1'b1;
      m_addr   = 0;
      m_csum   = 32'd0;
      beat(32'hAAAA_0001, 1'b0);
      ld_start = 1'b0;
      chk("restart_words", 32'(words_loaded), 32'd1);
      chk_status("restart_status", S_LOAD);
      beat(32'h1234_5678, 1'b1);
      finish_release(2, 1'b0);
      fetch("restart_pc0", 32'd0, 32'hAAAA_0001);
      fetch("restart_pc4", 32'd4, 32'h1234_5678);

      // Randomized loads; some pulse ld_start during RELEASE, which must be ignored.
      for (int r = 0; r < 6; r++) begin
         random_load(int'($urandom_range(1, DEPTH)), r[0]);
      end
      random_load(int'(DEPTH), 1'b0);

      // Asynchronous reset mid-load.
      do_start();
      for (int i = 0; i < 3; i++) beat($urandom, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("midload_reset");
      step();
      rst_n = 1'b1;
      step();
      step();
      chk_status("idle_no_autostart", S_IDLE);
      chk("idle_words", 32'(words_loaded), 32'd0);
      random_load(4, 1'b0);

`ifdef IMEM_LOAD_CSUM_EN
      do_start();
      beat_cs(32'h1, 1'b0, 32'd0);
      beat_cs(32'h2, 1'b1, 32'h3);
      finish_release(2, 1'b0);
      do_start();
      beat_cs(32'h1, 1'b0, 32'd0);
      beat_cs(32'h2, 1'b1, 32'h4);
      chk_status("csum_bad_err", S_ERR);
      chk("csum_bad_words", 32'(words_loaded), 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so a stuck run still terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_imem_load_ctrl
